// File: rtl/jesd204b_pkg.sv
// jesd204b_pkg: shared constants, mode encoding and lock-count helper for the JESD204B scrambler
package jesd204b_pkg;
  localparam int SCR_STATE_W = 15;
  localparam int SCR_TAP_A = 14;
  localparam int SCR_TAP_B = 15;
  localparam logic [SCR_STATE_W-1:0] SCR_DEFAULT_SEED = 15'h7F80;
  localparam int LOCK_CNT_W = 4;
  typedef enum logic [1:0] {
    MODE_DESCR  = 2'd0,
    MODE_SCR    = 2'd1,
    MODE_BYPASS = 2'd2
  } scr_mode_e;
  function automatic logic [LOCK_CNT_W-1:0] lock_cnt_add(input logic [LOCK_CNT_W-1:0] cnt, input int unsigned w);
    int unsigned sum;
    sum = cnt + w;
    return (sum >= SCR_STATE_W) ? LOCK_CNT_W'(SCR_STATE_W) : sum[LOCK_CNT_W-1:0];
  endfunction
endpackage

// File: rtl/jesd204b_scr_lane.sv
// jesd204b_scr_lane: one lane of 1+x^14+x^15 self-synchronous (de)scrambling, whole beat unrolled
module jesd204b_scr_lane
  import jesd204b_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [SCR_STATE_W-1:0] state_in,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  scr_mode_e              mode,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic [SCR_STATE_W-1:0] state_next
);
  // st[k] is the scrambled-stream bit k+1 positions back; MSB of the beat goes first
  always_comb begin
    logic [SCR_STATE_W-1:0] st;
    logic o;
    st = state_in;
    o = 1'b0;
    data_out = '0;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      o = (mode == MODE_BYPASS) ? data_in[i] : data_in[i] ^ st[SCR_TAP_A-1] ^ st[SCR_TAP_B-1];
      data_out[i] = o;
      st = {st[SCR_STATE_W-2:0], (mode == MODE_SCR) ? o : data_in[i]};
    end
    state_next = st;
  end
endmodule

// File: rtl/jesd204b_scrambler_array.sv
// jesd204b_scrambler_array: multi-lane JESD204B scrambler/descrambler with lock and one-stage valid/ready output
module jesd204b_scrambler_array
  import jesd204b_pkg::*;
#(
  parameter int                     LANES      = 4,
  parameter int                     DATA_WIDTH = 32,
  parameter logic [SCR_STATE_W-1:0] SEED       = SCR_DEFAULT_SEED
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        scr_mode,
  input  logic                        bypass,
  input  logic [LANES*DATA_WIDTH-1:0] in_data,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES-1:0]            lock
);
  logic [LANES*DATA_WIDTH-1:0] data_q, data_d, lane_out;
  logic valid_q, valid_d, accept;
  logic [LANES-1:0][SCR_STATE_W-1:0] state_q, state_d, state_base, state_nx;
  logic [LANES-1:0][LOCK_CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [LANES-1:0] lock_q, lock_d;
  scr_mode_e mode;
  assign in_ready = !valid_q || out_ready;
  assign accept = in_valid && in_ready;
  assign mode = bypass ? MODE_BYPASS : (scr_mode ? MODE_SCR : MODE_DESCR);
  // clr substitutes SEED ahead of the lanes so a same-cycle beat starts from the seed
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      state_base[i] = clr ? SEED : state_q[i];
      cnt_base[i] = clr ? '0 : cnt_q[i];
    end
  end
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    jesd204b_scr_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .state_in  (state_base[l]),
      .data_in   (in_data[l*DATA_WIDTH +: DATA_WIDTH]),
      .mode      (mode),
      .data_out  (lane_out[l*DATA_WIDTH +: DATA_WIDTH]),
      .state_next(state_nx[l])
    );
  end
  always_comb begin
    valid_d = accept || (valid_q && !out_ready);
    data_d = accept ? lane_out : data_q;
    for (int i = 0; i < LANES; i++) begin
      state_d[i] = accept ? state_nx[i] : state_base[i];
      cnt_d[i] = accept ? lock_cnt_add(cnt_base[i], DATA_WIDTH) : cnt_base[i];
      lock_d[i] = cnt_d[i] >= LOCK_CNT_W'(SCR_STATE_W);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q <= '0;
      state_q <= {LANES{SEED}};
      cnt_q <= '0;
      lock_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q <= data_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      lock_q <= lock_d;
    end
  end
  assign out_data = data_q;
  assign out_valid = valid_q;
  assign lock = lock_q;
endmodule

// File: tb/tb_jesd204b_scrambler_array.sv
// tb_jesd204b_scrambler_array: scoreboard bench for the scrambler array plus a scramble->descramble loopback
module tb_jesd204b_scrambler_array;
  typedef struct packed {
    logic [127:0] d;
    logic [3:0]   l;
  } item_t;

  logic clk = 1'b0, reset = 1'b1, clr = 1'b0, scr_mode = 1'b0, bypass = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [127:0] in_data = '0;
  logic in_ready, out_valid;
  logic [127:0] out_data;
  logic [3:0] lock;

  logic [127:0] a_data = '0;
  logic a_valid = 1'b0, b_rdy = 1'b1, lb_run = 1'b0;
  logic a_in_ready, ab_valid, b_in_ready, b_valid;
  logic [127:0] ab_data, b_data;
  logic [3:0] a_lock, b_lock;

  int n_cmp = 0, n_err = 0, lb_idx = 0;
  item_t exp_q[$];
  logic [127:0] lb_q[$];
  logic [14:0] mst[4];
  int mcnt[4];

  always #5 clk = ~clk;

  jesd204b_scrambler_array #(.LANES(4), .DATA_WIDTH(32), .SEED(15'h0000)) dut (
    .clk(clk), .reset(reset), .clr(clr), .scr_mode(scr_mode), .bypass(bypass),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .lock(lock)
  );

  jesd204b_scrambler_array #(.LANES(4), .DATA_WIDTH(32), .SEED(15'h7F80)) u_a (
    .clk(clk), .reset(reset), .clr(1'b0), .scr_mode(1'b1), .bypass(1'b0),
    .in_data(a_data), .in_valid(a_valid), .in_ready(a_in_ready),
    .out_data(ab_data), .out_valid(ab_valid), .out_ready(b_in_ready), .lock(a_lock)
  );

  jesd204b_scrambler_array #(.LANES(4), .DATA_WIDTH(32), .SEED(15'h1234)) u_b (
    .clk(clk), .reset(reset), .clr(1'b0), .scr_mode(1'b0), .bypass(1'b0),
    .in_data(ab_data), .in_valid(ab_valid), .in_ready(b_in_ready),
    .out_data(b_data), .out_valid(b_valid), .out_ready(b_rdy), .lock(b_lock)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // s[] is the scrambled stream in time order; s[0..14] is the incoming state, oldest first
  function automatic void model_beat(input logic [14:0] st, input logic [31:0] d, input int mode,
                                     output logic [31:0] o, output logic [14:0] nst);
    logic s [0:46];
    logic b;
    for (int k = 0; k < 15; k++) s[k] = st[14-k];
    for (int n = 0; n < 32; n++) begin
      b = d[31-n];
      o[31-n] = (mode == 2) ? b : b ^ s[n+1] ^ s[n];
      s[n+15] = (mode == 1) ? o[31-n] : b;
    end
    for (int k = 0; k < 15; k++) nst[14-k] = s[32+k];
  endfunction

  task automatic drive(input logic [127:0] d, input logic m, input logic b, input logic c);
    int g;
    item_t it;
    logic [31:0] o;
    logic [14:0] ns;
    g = 0;
    in_data = d; scr_mode = m; bypass = b; clr = c; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && g < 50) begin @(negedge clk); g++; end
    if (!in_ready) check("accept_timeout", in_ready, 1);
    else begin
      for (int l = 0; l < 4; l++) begin
        if (c) begin mst[l] = 15'h0; mcnt[l] = 0; end
        model_beat(mst[l], d[l*32 +: 32], b ? 2 : (m ? 1 : 0), o, ns);
        mst[l] = ns;
        mcnt[l] = (mcnt[l] + 32 > 15) ? 15 : mcnt[l] + 32;
        it.d[l*32 +: 32] = o;
        it.l[l] = (mcnt[l] >= 15);
      end
      exp_q.push_back(it);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; clr = 1'b0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("d0_extra_beat", out_valid, 0);
      else begin
        item_t e;
        e = exp_q.pop_front();
        check("d0_data", out_data, e.d);
        check("d0_lock", lock, e.l);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && b_valid && b_rdy) begin
      if (lb_q.size() == 0) check("lb_extra_beat", b_valid, 0);
      else begin
        logic [127:0] e;
        e = lb_q.pop_front();
        if (lb_idx > 0) check("lb_data", b_data, e);
        lb_idx++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    b_rdy = lb_run ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  initial begin
    logic [127:0] d;
    for (int l = 0; l < 4; l++) begin mst[l] = 15'h0; mcnt[l] = 0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_lock", lock, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk); #1 out_ready = 1'b1;

    d = rnd128();
    d[31:0] = 32'h8000_0000;
    drive(d, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("seed0_beat1", out_data[31:0], 32'h8003_0000);
    check("seed0_lock", lock, 4'hF);
    @(posedge clk); #1;
    d = rnd128();
    d[31:0] = 32'h0;
    drive(d, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("seed0_beat2", out_data[31:0], 32'h0);
    @(posedge clk); #1;

    repeat (20) drive(rnd128(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

    repeat (3) begin
      d = rnd128();
      drive(d, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      @(negedge clk);
      check("bypass_pass", out_data, d);
      @(posedge clk); #1;
    end
    repeat (3) drive(rnd128(), 1'b0, 1'b0, 1'b0);

    drive('0, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("clr_beat", out_data, 0);
    @(posedge clk); #1;
    drive('0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("clr_state", out_data, 0);
    @(posedge clk); #1;

    repeat (4) drive(rnd128(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    for (int l = 0; l < 4; l++) begin mst[l] = 15'h0; mcnt[l] = 0; end
    repeat (4) drive(rnd128(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

    out_ready = 1'b0;
    fork
      repeat (8) drive(rnd128(), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      begin
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_out_valid", out_valid, 1);
        end
        @(posedge clk); #1 out_ready = 1'b1;
      end
    join

    lb_run = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      int g;
      @(posedge clk); #1;
      a_data = rnd128();
      a_valid = 1'b1;
      g = 0;
      @(negedge clk);
      while (!a_in_ready && g < 50) begin @(negedge clk); g++; end
      if (!a_in_ready) begin
        check("lb_accept_timeout", a_in_ready, 1);
        break;
      end
      lb_q.push_back(a_data);
    end
    @(posedge clk); #1 a_valid = 1'b0;
    lb_run = 1'b0;
    for (int g = 0; g < 50 && (exp_q.size() != 0 || lb_q.size() != 0); g++) @(negedge clk);
    check("d0_drained", exp_q.size(), 0);
    check("lb_drained", lb_q.size(), 0);
    check("lb_count", lb_idx, 1000);

    @(posedge clk); #1 out_ready = 1'b0;
    drive(rnd128(), 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_lock", lock, 0);
    check("midrst_in_ready", in_ready, 1);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/jesd204b_scrambler_array.md
Name: jesd204b_scrambler_array

Overview:
Multi-lane, clocked, self-synchronous JESD204B scrambler/descrambler using the polynomial 1 + x^14 + x^15. Each lane keeps its own 15-bit state register, and that state carries across beats.
- Mode is selectable at run time: descramble, scramble or bypass.
- Per-lane lock indication.
- Valid/ready handshake with one output register stage.
- Sits between the lane deframer/8b10b decode (RX) or the transport framer (TX) and the link layer.

Parameters:
- LANES, 4, number of independent lanes sharing one handshake.
- DATA_WIDTH, 32, bits per lane per beat; must be a multiple of 8 and at least 16.
- SEED, 15'h7F80, per-lane state value loaded at reset and on clr.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- clr  in  1  synchronous reload of all lane states to SEED and clear of all lock counters.
- scr_mode  in  1  0 = descramble, 1 = scramble; sampled with each accepted beat.
- bypass  in  1  1 = out equals in; sampled with each accepted beat; overrides scr_mode.
- in_data  in  LANES*DATA_WIDTH  lane l occupies [l*DATA_WIDTH +: DATA_WIDTH]; MSB is the earliest bit in time.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat.
- out_data  out  LANES*DATA_WIDTH  processed beat, same lane mapping as in_data.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts out_data.
- lock  out  LANES  lane has consumed at least 15 bits since reset/clr.

Behaviour:
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - A beat is accepted when in_valid && in_ready.
  - An accepted beat appears on out_data with out_valid=1 on the next cycle. Latency is exactly 1 cycle.
  - While out_valid && !out_ready, out_data and out_valid hold unchanged, and no state update occurs.
  - No bubble: accept and drain happen in the same cycle at full throughput.
- Bit processing per lane on an accepted beat:
  - Bits are processed from MSB to LSB. s[n] denotes the scrambled-stream bit, and state holds the last 15 scrambled bits, with state[14] the oldest.
  - Descramble: out[n] = in[n] ^ s[n-14] ^ s[n-15]; s[n] = in[n].
  - Scramble: out[n] = in[n] ^ s[n-14] ^ s[n-15]; s[n] = out[n].
  - Bypass: out[n] = in[n]; s[n] = in[n]. State keeps tracking, so leaving bypass into descramble mode is immediately synchronised.
  - The whole beat is unrolled combinationally. Later bits within the beat use the s[] values of earlier bits of the same beat.
  - The next state is the last 15 s[] bits of the beat.
- Lock:
  - A per-lane saturating counter adds DATA_WIDTH per accepted beat and saturates at 15.
  - lock[l] = (count >= 15), registered.
  - Before lock, output is computed from SEED-based state and is well defined.
  - After lock, descramble output is independent of SEED.
- clr:
  - Has priority over the registered state.
  - If a beat is accepted in the same cycle, it is processed starting from SEED. The resulting state is stored, and the lock count becomes min(DATA_WIDTH, 15).
  - clr does not touch out_data or out_valid.
- reset:
  - out_valid=0, out_data=0, lock=0, all states=SEED, all counters=0.
  - in_ready=1 on the first cycle after reset.
  - Reset asserted mid-stream discards the pending output beat.
- Mode inputs only affect the beat accepted in the same cycle. A mode change between beats takes effect cleanly, with no state flush.

Decomposition:
- Package jesd204b_pkg holds:
  - SCR_STATE_W = 15, SCR_TAP_A = 14, SCR_TAP_B = 15, SCR_DEFAULT_SEED = 15'h7F80;
  - a mode encoding type for descramble/scramble/bypass.
- Sub-module jesd204b_scr_lane: purely combinational, DATA_WIDTH-parameterised. Takes state_in, data_in and mode, and produces data_out and state_next. It is instantiated LANES times.
- The top holds the output register, state registers, lock counters and handshake.

Test Plan:
- SEED=0, descramble, lane0 in=32'h8000_0000 then 32'h0000_0000 -> out 32'h8003_0000 then 32'h0000_0000; lock[0]=1 after the first beat.
- Loopback: instance A in scramble mode feeds instance B in descramble mode (different SEEDs). Send 1000 random beats on 4 lanes -> every beat after B's first beat equals A's input; lanes stay independent.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0, out_data held, states unchanged. On release, the beat sequence has no loss or duplication and matches the no-stall golden output.
- clr with a concurrent accepted beat, SEED=0, scramble, in=0 -> out=0, state stays 0. A mid-stream clr -> the next output matches a fresh instance.
- Bypass toggled mid-stream, then descramble -> bypass beats pass unchanged; the first post-bypass descrambled beat is already correct.
- reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, lock=0, in_ready=1.
